// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA image painter.
//   mode_e      : tile-select mode (all tiles, tile 0, tile 1, blank)
//   rgb24_t     : packed 8/8/8 colour
//   BG_DEFAULT  : default background colour
//   default_pal : palette contents loaded on reset
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_ALL   = 2'd0,
    MODE_T0    = 2'd1,
    MODE_T1    = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam logic [23:0] BG_DEFAULT = 24'h0C1990;

  function automatic rgb24_t default_pal(input int unsigned idx);
    rgb24_t c;
    case (idx)
      0:       c = 24'h000000;
      1:       c = 24'hFFFF00;
      2:       c = 24'h00FF00;
      3:       c = 24'hFFFFFF;
      4:       c = 24'h000050;
      5:       c = 24'h005050;
      6:       c = 24'h500050;
      7:       c = 24'h505050;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_palette.sv
// Colour palette register file.
//   clk, rst : clock, asynchronous active-high reset (loads default colours)
//   i_we     : write enable; i_wrgb stored at i_widx on the clock edge
//   i_ridx   : NUM_RD packed read indices
//   o_rrgb   : NUM_RD packed 24-bit colours, combinational (pre-write value
//              is seen during the write cycle)
module vga_palette
  import vga_pkg::*;
#(
  parameter int unsigned PIX_BITS = 3,
  parameter int unsigned NUM_RD   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_we,
  input  logic [PIX_BITS-1:0]        i_widx,
  input  rgb24_t                     i_wrgb,
  input  logic [NUM_RD*PIX_BITS-1:0] i_ridx,
  output logic [NUM_RD*24-1:0]       o_rrgb
);

  localparam int unsigned DEPTH = 1 << PIX_BITS;

  rgb24_t r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[PIX_BITS'(i)] <= default_pal(i);
      end
    end else if (i_we) begin
      r_mem[i_widx] <= i_wrgb;
    end
  end

  always_comb begin
    o_rrgb = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      o_rrgb[k*24 +: 24] = r_mem[i_ridx[k*PIX_BITS +: PIX_BITS]];
    end
  end

endmodule

// File: rtl/vga_image_painter.sv
// Paints NUM_IMG palette-indexed image tiles, left to right, onto a VGA scan.
//   clk, rst          : pixel clock, asynchronous active-high reset
//   X, Y, video_on    : current scan position and active-display qualifier
//   mode              : tile select, latched only at X==0,Y==0
//   mem_addr          : row*IMG_W+col inside the hit tile (0 when no hit)
//   pix_in            : per-tile palette index, MEM_LAT cycles after mem_addr
//   pal_we/idx/rgb    : palette write port
//   Red, Green, Blue  : registered colour, MEM_LAT+1 cycles after X/Y
module vga_image_painter
  import vga_pkg::*;
#(
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned PIX_BITS = 3,
  parameter int unsigned NUM_IMG  = 2,
  parameter int unsigned ORG_X    = 125,
  parameter int unsigned ORG_Y    = 150,
  parameter int unsigned GAP      = 0,
  parameter int unsigned MEM_LAT  = 1,
  parameter logic [23:0] BG_RGB   = BG_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    X,
  input  logic [9:0]                    Y,
  input  logic                          video_on,
  input  logic [1:0]                    mode,
  output logic [$clog2(IMG_W*IMG_H)-1:0] mem_addr,
  input  logic [NUM_IMG*PIX_BITS-1:0]   pix_in,
  input  logic                          pal_we,
  input  logic [PIX_BITS-1:0]           pal_idx,
  input  logic [23:0]                   pal_rgb,
  output logic [7:0]                    Red,
  output logic [7:0]                    Green,
  output logic [7:0]                    Blue
);

  localparam int unsigned AW    = $clog2(IMG_W*IMG_H);
  localparam int unsigned TW    = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;
  localparam int unsigned PITCH = IMG_W + GAP;

  mode_e            r_mode;
  logic             r_hit_d  [MEM_LAT];
  logic             r_vid_d  [MEM_LAT];
  logic [TW-1:0]    r_tile_d [MEM_LAT];
  rgb24_t           r_rgb;

  logic [31:0]      w_x;
  logic [31:0]      w_y;
  logic [31:0]      w_col;
  logic [31:0]      w_row;
  logic             w_y_in;
  logic             w_geo;
  logic             w_tile_en;
  logic             w_hit;
  logic [TW-1:0]    w_tile;
  logic [NUM_IMG*24-1:0] w_pal_rd;
  rgb24_t           w_sel;

  // Stage 0: coordinate decode, purely combinational
  always_comb begin
    w_x    = 32'(X);
    w_y    = 32'(Y);
    w_y_in = (w_y >= ORG_Y) && (w_y < ORG_Y + IMG_H);
    w_geo  = 1'b0;
    w_tile = '0;
    w_col  = '0;
    for (int unsigned t = 0; t < NUM_IMG; t++) begin
      if ((w_x >= ORG_X + t*PITCH) && (w_x < ORG_X + t*PITCH + IMG_W)) begin
        w_geo  = 1'b1;
        w_tile = TW'(t);
        w_col  = w_x - (ORG_X + t*PITCH);
      end
    end
    w_row = w_y - ORG_Y;
    case (r_mode)
      MODE_ALL: w_tile_en = 1'b1;
      MODE_T0:  w_tile_en = (w_tile == TW'(0));
      MODE_T1:  w_tile_en = (w_tile == TW'(1));
      default:  w_tile_en = 1'b0;
    endcase
    w_hit    = w_geo && w_y_in && w_tile_en;
    mem_addr = w_hit ? AW'(w_row * IMG_W + w_col) : '0;
  end

  // Delay pipeline aligning hit/tile/video_on with pix_in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_ALL;
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        r_hit_d[i]  <= 1'b0;
        r_vid_d[i]  <= 1'b0;
        r_tile_d[i] <= '0;
      end
    end else begin
      if (X == 10'd0 && Y == 10'd0) begin
        r_mode <= mode_e'(mode);
      end
      r_hit_d[0]  <= w_hit;
      r_vid_d[0]  <= video_on;
      r_tile_d[0] <= w_tile;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        r_hit_d[i]  <= r_hit_d[i-1];
        r_vid_d[i]  <= r_vid_d[i-1];
        r_tile_d[i] <= r_tile_d[i-1];
      end
    end
  end

  vga_palette #(
    .PIX_BITS (PIX_BITS),
    .NUM_RD   (NUM_IMG)
  ) u_pal (
    .clk    (clk),
    .rst    (rst),
    .i_we   (pal_we),
    .i_widx (pal_idx),
    .i_wrgb (pal_rgb),
    .i_ridx (pix_in),
    .o_rrgb (w_pal_rd)
  );

  // Each tile has its own palette read port; pick the one for the hit tile
  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < NUM_IMG; k++) begin
      if (r_tile_d[MEM_LAT-1] == TW'(k)) begin
        w_sel = w_pal_rd[k*24 +: 24];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb <= '0;
    end else if (!r_vid_d[MEM_LAT-1]) begin
      r_rgb <= '0;
    end else if (r_hit_d[MEM_LAT-1]) begin
      r_rgb <= w_sel;
    end else begin
      r_rgb <= BG_RGB;
    end
  end

  assign Red   = r_rgb.r;
  assign Green = r_rgb.g;
  assign Blue  = r_rgb.b;

endmodule
